imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the instruction memory: accepts a framed byte stream (length header, little-endian instruction words, XOR checksum) over a valid/ready interface, assembles 32-bit words and drives the instruction-memory write port from word address 0 upward. It holds the processor core in reset until a frame completes with a good checksum, and reports errors. It sits between the byte link (I2C/UART receiver) and the memory the core's fetch path reads.

## Interface
- DEPTH, 256, instruction-memory depth in 32-bit words; must be a power of two, at most 65536
- AW, log2(DEPTH), word-address width of the write port
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready
- load_req  in  1  single-cycle pulse; restarts loading from DONE or ERR
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_waddr  out  AW  word address of the write
- mem_wdata  out  32  assembled instruction word
- core_rst  out  1  reset to the core; high except in DONE
- done  out  1  frame loaded and checksum good
- error  out  1  frame rejected (length too large or checksum mismatch)

## Operation
- Frame: LEN_LO, LEN_HI (N = 16-bit word count), 4·N payload bytes (each word least-significant byte first), one CSUM byte.
- CSUM must equal the XOR of every preceding frame byte, header included.
- Running XOR register: cleared on entry to LEN_LO; updated on every accepted byte except CSUM.
- States and transitions:
  - LEN_LO: accept a byte, store it as N[7:0], go to LEN_HI.
  - LEN_HI: accept a byte, store it as N[15:8]. If N > DEPTH go to ERR. If N == 0 go to CSUM. Otherwise go to DATA.
  - DATA: accept bytes into a byte lane indexed by a 2-bit counter. On the 4th byte, register the write (mem_we=1 next cycle) and increment the word counter. After word N−1 go to CSUM.
  - CSUM: accept a byte. If it equals the XOR register go to DONE, else go to ERR.
  - DONE: sticky.
  - ERR: sticky.
  - From DONE or ERR, a load_req pulse goes to LEN_LO and clears done, error and the counters. load_req is ignored in all other states.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in DONE and ERR. The loader never stalls mid-frame.
- Width rules:
  - Word counter is AW+1 bits, so that N == DEPTH is legal and writes addresses 0..DEPTH−1.
  - The comparison against N is done in 17 bits.
  - mem_waddr is the word counter truncated to AW bits.
- Memory contents written before an error are not rolled back. The core stays in reset, so they are never fetched.
- Gaps (in_valid=0) in any accepting state hold all state.

## Timing
- Reset values:
  - state=LEN_LO, in_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0
  - core_rst=1, done=0, error=0
  - XOR register, byte lane and word counter all 0
- Reset mid-frame discards the partial word and frame. No write is issued in the reset cycle, even if a 4th byte was presented.
- Write latency: mem_we, mem_waddr and mem_wdata are registered outputs, valid exactly one cycle after the 4th byte's transfer cycle. mem_we is high for one cycle per word.
- Back-to-back bytes: one write every 4 cycles at most; mem_we is never high on consecutive cycles.
- done and core_rst change in the cycle after the CSUM transfer: done=1 and core_rst=0 together.
- error rises in the cycle after the LEN_HI or CSUM transfer that caused it.
- load_req and in_valid in the same cycle in DONE/ERR: the loader takes load_req and does not accept the byte (in_ready=0 that cycle).

## Structure
- Shared package imem_loader_pkg holds:
  - state enum (LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR)
  - frame constant BYTES_PER_WORD=4
- Natural sub-module: byte_packer, a 4-byte little-endian shift/lane assembler with a word_valid pulse and clear input.
- The FSM, counters and checksum logic live in imem_loader.
- The instruction memory gains a write port (we, waddr, wdata) next to the existing combinational fetch read port.

## Test plan
- Normal frame: N=2, bytes 02 00 13 05 10 00 B3 05 B5 00, CSUM=XOR of those 10 bytes.
  - Required: writes addr0=0x00100513 and addr1=0x00B505B3, each one cycle after its 4th byte.
  - Required: done=1 and core_rst=0 the cycle after CSUM; in_ready=0 thereafter.
- Bad checksum: same frame with CSUM XOR 0x01.
  - Required: both writes occur, error=1, done=0, core_rst stays 1; load_req returns in_ready=1 and error=0.
- Oversize: DEPTH=256, header 01 01 (N=257).
  - Required: error=1 the cycle after the header; zero writes.
- Empty frame: 00 00 then CSUM 00.
  - Required: done=1 with no mem_we.
- Edge and stall: N=DEPTH with random in_valid gaps.
  - Required: last write at addr DEPTH−1; no address wrap; mem_we pulses never adjacent.
- Reset mid-word: assert rst together with the 3rd payload byte.
  - Required: no write; next frame's first word lands at addr 0 with correct bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StLenLo,
      StLenHi,
      StData,
      StCsum,
      StDone,
      StErr
   } state_e;

   localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-lane assembler: collects BYTES_PER_WORD bytes into one word and
// pulses word_valid_o in the cycle the last byte arrives.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear_i,
   input  logic                          valid_i,
   input  logic [7:0]                    byte_i,
   output logic                          word_valid_o,
   output logic [8*BYTES_PER_WORD-1:0]   word_o
);

   localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

   logic [LaneW-1:0]              lane_q, lane_d;
   logic [8*BYTES_PER_WORD-1:0]   word_q, word_d;
   logic                          last_lane;

   assign last_lane = (lane_q == LaneW'(BYTES_PER_WORD - 1));

   // word_o already carries the incoming byte so the top can register a complete word.
   always_comb begin
      lane_d       = lane_q;
      word_d       = word_q;
      word_o       = word_q;
      word_valid_o = valid_i && last_lane;
      if (valid_i) begin
         word_o[8*lane_q +: 8] = byte_i;
      end
      if (clear_i) begin
         lane_d = '0;
         word_d = '0;
      end else if (valid_i) begin
         lane_d = lane_q + LaneW'(1);
         word_d = word_o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte frame, writes assembled words to
// instruction memory from address 0 and releases the core reset once the frame checks out.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          load_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [31:0]   mem_wdata,
   output logic          core_rst,
   output logic          done,
   output logic          error
);

   localparam logic [16:0] DepthW = 17'(DEPTH);

   state_e        state_q, state_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    xor_q, xor_d;
   logic [AW:0]   wcnt_q, wcnt_d;
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;

   logic          accept;
   logic          pk_valid;
   logic          pk_clear;
   logic          pk_word_valid;
   logic [31:0]   pk_word;
   logic [15:0]   len_full;

   assign in_ready = (state_q != StDone) && (state_q != StErr);
   assign accept   = in_valid && in_ready;
   assign pk_valid = accept && (state_q == StData);
   assign len_full = {in_data, len_q[7:0]};

   imem_loader_byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (pk_clear),
      .valid_i      (pk_valid),
      .byte_i       (in_data),
      .word_valid_o (pk_word_valid),
      .word_o       (pk_word)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      xor_d    = xor_q;
      wcnt_d   = wcnt_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      pk_clear = 1'b0;

      unique case (state_q)
         StLenLo: begin
            if (accept) begin
               len_d[7:0] = in_data;
               xor_d      = xor_q ^ in_data;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (accept) begin
               len_d[15:8] = in_data;
               xor_d       = xor_q ^ in_data;
               if ({1'b0, len_full} > DepthW) begin
                  state_d = StErr;
               end else if (len_full == 16'd0) begin
                  state_d = StCsum;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               xor_d = xor_q ^ in_data;
               if (pk_word_valid) begin
                  we_d    = 1'b1;
                  waddr_d = wcnt_q[AW-1:0];
                  wdata_d = pk_word;
                  wcnt_d  = wcnt_q + 1'b1;
                  // Compare in 17 bits so a full-depth frame terminates without wrapping.
                  if (17'(wcnt_q) + 17'd1 == {1'b0, len_q}) begin
                     state_d = StCsum;
                  end
               end
            end
         end
         StCsum: begin
            if (accept) begin
               state_d = (in_data == xor_q) ? StDone : StErr;
            end
         end
         StDone, StErr: begin
            if (load_req) begin
               state_d  = StLenLo;
               len_d    = '0;
               xor_d    = '0;
               wcnt_d   = '0;
               pk_clear = 1'b1;
            end
         end
         default: state_d = StLenLo;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLenLo;
         len_q   <= '0;
         xor_q   <= '0;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         xor_q   <= xor_d;
         wcnt_q  <= wcnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign done      = (state_q == StDone);
   assign error     = (state_q == StErr);
   assign core_rst  = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table for the reference frame, then directed
// corner cases and random frames checked against a frame-level model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_ready;
   logic          load_req = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic          core_rst;
   logic          done;
   logic          error;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] wlog_addr[$];
   logic [31:0] wlog_data[$];
   logic        prev_we  = 1'b0;
   int          adj_viol = 0;
   logic [7:0]  frame_q[$];

   typedef struct {
      logic [7:0]  data;
      logic        valid;
      logic        load;
      logic        ready;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        done;
      logic        err;
      logic        crst;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   imem_loader #(
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .load_req  (load_req),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .core_rst  (core_rst),
      .done      (done),
      .error     (error)
   );

   // Write monitor: logs every write and counts back-to-back strobes.
   always @(negedge clk) begin
      if (mem_we) begin
         wlog_addr.push_back(32'(mem_waddr));
         wlog_data.push_back(mem_wdata);
         if (prev_we) adj_viol <= adj_viol + 1;
      end
      prev_we <= mem_we;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l,
                               input logic rdy, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic dn, input logic er,
                               input logic cr);
      vec_t r;
      r.data = d; r.valid = v; r.load = l; r.ready = rdy; r.we = we;
      r.addr = a; r.wdata = wd; r.done = dn; r.err = er; r.crst = cr;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load(input string tag);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      check({tag, "_reload_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_reload_error"}, 32'(error), 32'd0);
      check({tag, "_reload_done"}, 32'(done), 32'd0);
   endtask

   // Builds header, random payload and checksum; corrupt flips the checksum.
   task automatic build_frame(input int n, input bit corrupt);
      logic [15:0] nn;
      logic [7:0]  x;
      nn = 16'(n);
      frame_q.delete();
      frame_q.push_back(nn[7:0]);
      frame_q.push_back(nn[15:8]);
      if (n <= int'(DEPTH)) begin
         for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
         x = 8'h00;
         foreach (frame_q[i]) x ^= frame_q[i];
         if (corrupt) x ^= 8'(1 << $urandom_range(7, 0));
         frame_q.push_back(x);
      end
   endtask

   // Sends frame_q and checks each write and the outcome against the frame-level model.
   task automatic run_frame(input int max_gap, input string tag);
      int          n;
      int          nsent;
      int          base_cnt;
      int          base_adj;
      bit          over;
      bit          ok;
      logic [7:0]  x;
      logic [31:0] w;
      n        = int'({frame_q[1], frame_q[0]});
      over     = (n > int'(DEPTH));
      base_cnt = wlog_addr.size();
      base_adj = adj_viol;
      ok       = 1'b0;
      if (!over) begin
         x = 8'h00;
         for (int i = 0; i < frame_q.size() - 1; i++) x ^= frame_q[i];
         ok = (frame_q[frame_q.size() - 1] == x);
      end
      nsent = over ? 2 : frame_q.size();
      for (int k = 0; k < nsent; k++) begin
         if (max_gap > 0) idle($urandom_range(max_gap, 0));
         send_byte(frame_q[k]);
         if (!over && k >= 2 && k < 2 + 4 * n && ((k - 2) % 4) == 3) begin
            w = {frame_q[k], frame_q[k-1], frame_q[k-2], frame_q[k-3]};
            check({tag, "_we"}, 32'(mem_we), 32'd1);
            check({tag, "_waddr"}, 32'(mem_waddr), 32'((k - 2) / 4));
            check({tag, "_wdata"}, mem_wdata, w);
         end
      end
      if (over) begin
         check({tag, "_error"}, 32'(error), 32'd1);
         check({tag, "_done"}, 32'(done), 32'd0);
         check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
      end else begin
         check({tag, "_done"}, 32'(done), 32'(ok));
         check({tag, "_error"}, 32'(error), 32'(!ok));
         check({tag, "_core_rst"}, 32'(core_rst), 32'(!ok));
      end
      check({tag, "_ready_after"}, 32'(in_ready), 32'd0);
      idle(2);
      #1;
      check({tag, "_write_count"}, 32'(wlog_addr.size() - base_cnt), over ? 32'd0 : 32'(n));
      check({tag, "_we_adjacent"}, 32'(adj_viol - base_adj), 32'd0);
   endtask

   initial begin
      // Reference frame from the bring-up notes; checksum 07 is the XOR of the ten bytes.
      vecs[0]  = mk(8'h02, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[1]  = mk(8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[2]  = mk(8'h13, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[3]  = mk(8'h05, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[4]  = mk(8'h10, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[5]  = mk(8'h00, 1, 0, 1, 1, 32'd0, 32'h00100513, 0, 0, 1);
      vecs[6]  = mk(8'hB3, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[7]  = mk(8'h05, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[8]  = mk(8'hB5, 1, 0, 1, 0, 0, 0, 0, 0, 1);
      vecs[9]  = mk(8'h00, 1, 0, 1, 1, 32'd1, 32'h00B505B3, 0, 0, 1);
      vecs[10] = mk(8'h07, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[11] = mk(8'h55, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[12] = mk(8'h55, 1, 1, 1, 0, 0, 0, 0, 0, 1);

      rst = 1'b1;
      idle(2);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_waddr", 32'(mem_waddr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      rst = 1'b0;
      idle(1);

      for (int i = 0; i < 13; i++) begin
         in_data  = vecs[i].data;
         in_valid = vecs[i].valid;
         load_req = vecs[i].load;
         @(negedge clk);
         in_valid = 1'b0;
         load_req = 1'b0;
         check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].ready));
         check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
         check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
         check($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].err));
         check($sformatf("vec%0d_core_rst", i), 32'(core_rst), 32'(vecs[i].crst));
         if (vecs[i].we) begin
            check($sformatf("vec%0d_waddr", i), 32'(mem_waddr), vecs[i].addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdata);
         end
      end

      // Bad checksum: reference frame with checksum bit 0 flipped.
      frame_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00,
                  8'h06};
      run_frame(0, "badcsum");
      pulse_load("badcsum");

      frame_q = '{8'h01, 8'h01};
      run_frame(0, "oversize");
      pulse_load("oversize");

      frame_q = '{8'h00, 8'h00, 8'h00};
      run_frame(0, "empty");
      pulse_load("empty");

      build_frame(int'(DEPTH), 1'b0);
      run_frame(3, "full");
      check("full_last_addr", wlog_addr[wlog_addr.size() - 1], 32'(DEPTH - 1));
      pulse_load("full");

      for (int r = 0; r < 20; r++) begin
         if ($urandom_range(4, 0) == 0) build_frame(int'(DEPTH) + 1 + $urandom_range(2000, 0), 0);
         else build_frame($urandom_range(6, 0), 1'($urandom_range(1, 0)));
         run_frame($urandom_range(2, 0), $sformatf("rand%0d", r));
         pulse_load($sformatf("rand%0d", r));
      end

      // Reset arriving with the third payload byte: no write, frame discarded.
      begin
         int base_cnt;
         base_cnt = wlog_addr.size();
         send_byte(8'h01);
         send_byte(8'h00);
         send_byte(8'hAA);
         send_byte(8'hBB);
         in_valid = 1'b1;
         in_data  = 8'hCC;
         rst      = 1'b1;
         @(negedge clk);
         rst      = 1'b0;
         in_valid = 1'b0;
         check("midrst_we", 32'(mem_we), 32'd0);
         check("midrst_ready", 32'(in_ready), 32'd1);
         check("midrst_done", 32'(done), 32'd0);
         idle(2);
         #1;
         check("midrst_no_write", 32'(wlog_addr.size() - base_cnt), 32'd0);
         frame_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h67};
         run_frame(0, "after_rst");
         check("after_rst_addr", wlog_addr[wlog_addr.size() - 1], 32'd0);
         check("after_rst_data", wlog_data[wlog_data.size() - 1], 32'h44332211);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
